// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the serial ALU front end: receive states, packet
// types, command length and the valid-only CTL codes.
package mtm_alu_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE    = 3'd0;
    localparam rx_state_t ST_TYPE    = 3'd1;
    localparam rx_state_t ST_PAYLOAD = 3'd2;
    localparam rx_state_t ST_STOP    = 3'd3;
    localparam rx_state_t ST_RESYNC  = 3'd4;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CTL  = 1'b1;

    localparam int DATA_BYTES = 8;

    // CTL codes that carry no operation, shared with the output serializer
    localparam logic [7:0] CTL_VALID_0 = 8'hC9;
    localparam logic [7:0] CTL_VALID_1 = 8'h93;
    localparam logic [7:0] CTL_VALID_2 = 8'hA5;

endpackage

// File: rtl/mtm_alu_byte_rx.sv
// Packet-level receiver: start, type, 8 payload bits MSB first, stop.
// Emits the received byte/type with a one-cycle done or stop-error pulse.
module mtm_alu_byte_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic [7:0] rx_byte,
    output logic       rx_type,
    output logic       byte_done,
    output logic       stop_err
);

    rx_state_t  state_r;
    rx_state_t  state_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_s;
    logic       type_r;
    logic       type_s;
    logic       done_r;
    logic       done_s;
    logic       serr_r;
    logic       serr_s;

    // Next-state and datapath for one 11-bit packet
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        type_s    = type_r;
        done_s    = 1'b0;
        serr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sin == 1'b0) begin
                    state_s = ST_TYPE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TYPE: begin
                type_s    = sin;
                bit_cnt_s = 3'd0;
                state_s   = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                shift_s = {shift_r[6:0], sin};
                if (bit_cnt_r == 3'd7) begin
                    bit_cnt_s = 3'd0;
                    state_s   = ST_STOP;
                end else begin
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = ST_PAYLOAD;
                end
            end
            ST_STOP: begin
                // Returning to IDLE here lets a start bit follow the stop directly
                if (sin == 1'b1) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    serr_s  = 1'b1;
                    state_s = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (sin == 1'b1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESYNC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            type_r    <= PKT_DATA;
            done_r    <= 1'b0;
            serr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            type_r    <= type_s;
            done_r    <= done_s;
            serr_r    <= serr_s;
        end
    end

    assign rx_byte   = shift_r;
    assign rx_type   = type_r;
    assign byte_done = done_r;
    assign stop_err  = serr_r;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the ALU: collects 8 data packets into {B,A}, takes the
// control packet as CTL and presents them with a one-cycle valid pulse.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_BYTES = mtm_alu_pkg::DATA_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [7:0]  CTL,
    output logic        data_valid,
    output logic        err_frame,
    output logic        err_data
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_BYTES);

    logic [7:0]  rx_byte_s;
    logic        rx_type_s;
    logic        byte_done_s;
    logic        stop_err_s;

    logic [3:0]  count_r;
    logic [3:0]  count_s;
    logic [63:0] buf_r;
    logic [63:0] buf_s;
    logic [31:0] a_r;
    logic [31:0] a_s;
    logic [31:0] b_r;
    logic [31:0] b_s;
    logic [7:0]  ctl_r;
    logic [7:0]  ctl_s;
    logic        dv_s;
    logic        dv_r;
    logic        ef_s;
    logic        ef_r;
    logic        ed_s;
    logic        ed_r;

    mtm_alu_byte_rx u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .rx_byte   (rx_byte_s),
        .rx_type   (rx_type_s),
        .byte_done (byte_done_s),
        .stop_err  (stop_err_s)
    );

    // Commit rules for finished packets; only one pulse source per cycle
    always_comb begin
        count_s = count_r;
        buf_s   = buf_r;
        a_s     = a_r;
        b_s     = b_r;
        ctl_s   = ctl_r;
        dv_s    = 1'b0;
        ef_s    = 1'b0;
        ed_s    = 1'b0;
        if (stop_err_s) begin
            ef_s    = 1'b1;
            count_s = 4'd0;
        end else if (byte_done_s) begin
            if (rx_type_s == PKT_DATA) begin
                if (count_r < FULL_CNT) begin
                    buf_s   = {buf_r[55:0], rx_byte_s};
                    count_s = count_r + 4'd1;
                end else begin
                    ed_s    = 1'b1;
                    count_s = 4'd0;
                end
            end else begin
                if (count_r == FULL_CNT) begin
                    // First byte received ends up in the top of the buffer: B[31:24]
                    b_s   = buf_r[63:32];
                    a_s   = buf_r[31:0];
                    ctl_s = rx_byte_s;
                    dv_s  = 1'b1;
                end else begin
                    ed_s  = 1'b1;
                end
                count_s = 4'd0;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Command state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 4'd0;
            buf_r   <= 64'h0;
            a_r     <= 32'h0;
            b_r     <= 32'h0;
            ctl_r   <= 8'h00;
            dv_r    <= 1'b0;
            ef_r    <= 1'b0;
            ed_r    <= 1'b0;
        end else begin
            count_r <= count_s;
            buf_r   <= buf_s;
            a_r     <= a_s;
            b_r     <= b_s;
            ctl_r   <= ctl_s;
            dv_r    <= dv_s;
            ef_r    <= ef_s;
            ed_r    <= ed_s;
        end
    end

    assign A          = a_r;
    assign B          = b_r;
    assign CTL        = ctl_r;
    assign data_valid = dv_r;
    assign err_frame  = ef_r;
    assign err_data   = ed_r;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: drives line bits on the falling
// edge and checks outputs and pulse counts against hand-computed values.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sin = 1'b1;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  CTL;
    logic        data_valid;
    logic        err_frame;
    logic        err_data;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int dv_cnt   = 0;
    int ef_cnt   = 0;
    int ed_cnt   = 0;
    int multi_cnt = 0;
    int dv_edge  = -1;
    int bit_edge = 0;

    mtm_alu_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .A          (A),
        .B          (B),
        .CTL        (CTL),
        .data_valid (data_valid),
        .err_frame  (err_frame),
        .err_data   (err_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Pulse monitor: counts pulses and records the edge that raised data_valid
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt  <= dv_cnt + 1;
            dv_edge <= edge_cnt - 1;
        end
        if (err_frame) ef_cnt <= ef_cnt + 1;
        if (err_data)  ed_cnt <= ed_cnt + 1;
        if ((int'(data_valid) + int'(err_frame) + int'(err_data)) > 1) multi_cnt <= multi_cnt + 1;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_edge = edge_cnt;
        sin = b;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic t, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [7:0] c,
                            output int start);
        logic [63:0] ba;
        ba = {b, a};
        send_bit(1'b0);
        start = bit_edge;
        send_bit(1'b0);
        for (int i = 63; i >= 56; i--) send_bit(ba[i]);
        send_bit(1'b1);
        for (int k = 1; k < 8; k++) send_packet(1'b0, ba[63-8*k -: 8], 1'b1);
        send_packet(1'b1, c, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (A !== 32'h0)        begin errors++; $display("FAIL reset_A got %h exp %h", A, 32'h0); end
        checks++; if (B !== 32'h0)        begin errors++; $display("FAIL reset_B got %h exp %h", B, 32'h0); end
        checks++; if (CTL !== 8'h00)      begin errors++; $display("FAIL reset_CTL got %h exp %h", CTL, 8'h00); end
        checks++; if ({data_valid, err_frame, err_data} !== 3'b000)
            begin errors++; $display("FAIL reset_pulses got %b exp 000", {data_valid, err_frame, err_data}); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        int st, dv0, ef0, ed0;
        dv0 = dv_cnt; ef0 = ef_cnt; ed0 = ed_cnt;
        send_cmd(32'h01234567, 32'h89ABCDEF, 8'h2A, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count got %0d exp 1", dv_cnt - dv0); end
        checks++; if (dv_edge - st !== 99) begin errors++; $display("FAIL single_latency got %0d exp 99", dv_edge - st); end
        checks++; if (A !== 32'h89ABCDEF) begin errors++; $display("FAIL single_A got %h exp 89abcdef", A); end
        checks++; if (B !== 32'h01234567) begin errors++; $display("FAIL single_B got %h exp 01234567", B); end
        checks++; if (CTL !== 8'h2A)      begin errors++; $display("FAIL single_CTL got %h exp 2a", CTL); end
        checks++; if ((ef_cnt - ef0) + (ed_cnt - ed0) !== 0)
            begin errors++; $display("FAIL single_errors got %0d exp 0", (ef_cnt - ef0) + (ed_cnt - ed0)); end
    endtask

    task automatic test_back_to_back;
        int st, dv0;
        dv0 = dv_cnt;
        send_cmd(32'hDEADBEEF, 32'hCAFEF00D, 8'hC9, st);
        send_idle(1);
        send_cmd(32'h76543210, 32'hFEDCBA98, 8'h3C, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d exp 2", dv_cnt - dv0); end
        checks++; if (dv_edge - st !== 99) begin errors++; $display("FAIL b2b_latency got %0d exp 99", dv_edge - st); end
        checks++; if (A !== 32'hFEDCBA98) begin errors++; $display("FAIL b2b_A got %h exp fedcba98", A); end
        checks++; if (B !== 32'h76543210) begin errors++; $display("FAIL b2b_B got %h exp 76543210", B); end
        checks++; if (CTL !== 8'h3C)      begin errors++; $display("FAIL b2b_CTL got %h exp 3c", CTL); end
        send_idle(10);
        checks++; if (A !== 32'hFEDCBA98) begin errors++; $display("FAIL b2b_hold_A got %h exp fedcba98", A); end
    endtask

    task automatic test_short_cmd;
        int st, dv0, ed0;
        dv0 = dv_cnt; ed0 = ed_cnt;
        for (int k = 0; k < 5; k++) send_packet(1'b0, 8'(8'h40 + k), 1'b1);
        send_packet(1'b1, 8'h93, 1'b1);
        send_idle(4);
        checks++; if (ed_cnt - ed0 !== 1) begin errors++; $display("FAIL short_err_data got %0d exp 1", ed_cnt - ed0); end
        checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL short_dv got %0d exp 0", dv_cnt - dv0); end
        checks++; if (CTL !== 8'h3C)      begin errors++; $display("FAIL short_CTL_kept got %h exp 3c", CTL); end
        send_cmd(32'h13579BDF, 32'h2468ACE0, 8'hA5, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL short_recover_dv got %0d exp 1", dv_cnt - dv0); end
        checks++; if ({B, A, CTL} !== {32'h13579BDF, 32'h2468ACE0, 8'hA5})
            begin errors++; $display("FAIL short_recover_vals got %h %h %h exp 13579bdf 2468ace0 a5", B, A, CTL); end
        checks++; if (ed_cnt - ed0 !== 1) begin errors++; $display("FAIL short_recover_err got %0d exp 1", ed_cnt - ed0); end
    endtask

    task automatic test_nine_data;
        int st, dv0, ed0;
        dv0 = dv_cnt; ed0 = ed_cnt;
        for (int k = 0; k < 8; k++) send_packet(1'b0, 8'(8'h10 + k), 1'b1);
        send_idle(4);
        checks++; if (ed_cnt - ed0 !== 0) begin errors++; $display("FAIL nine_early_err got %0d exp 0", ed_cnt - ed0); end
        send_packet(1'b0, 8'h18, 1'b1);
        send_idle(4);
        checks++; if (ed_cnt - ed0 !== 1) begin errors++; $display("FAIL nine_err_data got %0d exp 1", ed_cnt - ed0); end
        send_cmd(32'h0F1E2D3C, 32'h4B5A6978, 8'h93, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL nine_recover_dv got %0d exp 1", dv_cnt - dv0); end
        checks++; if ({B, A, CTL} !== {32'h0F1E2D3C, 32'h4B5A6978, 8'h93})
            begin errors++; $display("FAIL nine_recover_vals got %h %h %h exp 0f1e2d3c 4b5a6978 93", B, A, CTL); end
    endtask

    task automatic test_frame_error;
        int st, dv0, ef0, ed0;
        dv0 = dv_cnt; ef0 = ef_cnt; ed0 = ed_cnt;
        send_packet(1'b0, 8'hAA, 1'b1);
        send_packet(1'b0, 8'h55, 1'b1);
        send_packet(1'b0, 8'hF0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        checks++; if (ef_cnt - ef0 !== 1) begin errors++; $display("FAIL frame_err got %0d exp 1", ef_cnt - ef0); end
        checks++; if ((dv_cnt - dv0) + (ed_cnt - ed0) !== 0)
            begin errors++; $display("FAIL frame_other_pulses got %0d exp 0", (dv_cnt - dv0) + (ed_cnt - ed0)); end
        send_idle(2);
        send_cmd(32'h11223344, 32'h55667788, 8'hC9, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL frame_recover_dv got %0d exp 1", dv_cnt - dv0); end
        checks++; if ({B, A, CTL} !== {32'h11223344, 32'h55667788, 8'hC9})
            begin errors++; $display("FAIL frame_recover_vals got %h %h %h exp 11223344 55667788 c9", B, A, CTL); end
        checks++; if ((ef_cnt - ef0) + (ed_cnt - ed0) !== 1)
            begin errors++; $display("FAIL frame_recover_errs got %0d exp 1", (ef_cnt - ef0) + (ed_cnt - ed0)); end
    endtask

    task automatic test_reset_mid_packet;
        int st, dv0, ef0, ed0;
        for (int k = 0; k < 5; k++) send_packet(1'b0, 8'(8'h70 + k), 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        dv0 = dv_cnt; ef0 = ef_cnt; ed0 = ed_cnt;
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({A, B, CTL} !== 72'h0) begin errors++; $display("FAIL midrst_outputs got %h exp 0", {A, B, CTL}); end
        rst = 1'b0;
        send_idle(3);
        checks++; if ((dv_cnt - dv0) + (ef_cnt - ef0) + (ed_cnt - ed0) !== 0)
            begin errors++; $display("FAIL midrst_pulses got %0d exp 0", (dv_cnt - dv0) + (ef_cnt - ef0) + (ed_cnt - ed0)); end
        send_cmd(32'hA5A5A5A5, 32'h5A5A5A5A, 8'h2A, st);
        send_idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midrst_recover_dv got %0d exp 1", dv_cnt - dv0); end
        checks++; if ({B, A, CTL} !== {32'hA5A5A5A5, 32'h5A5A5A5A, 8'h2A})
            begin errors++; $display("FAIL midrst_recover_vals got %h %h %h exp a5a5a5a5 5a5a5a5a 2a", B, A, CTL); end
    endtask

    task automatic test_pulse_exclusive;
        checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d exp 0", multi_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_short_cmd;
        test_nine_data;
        test_frame_error;
        test_reset_mid_packet;
        test_pulse_exclusive;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
